acc_step_counter: RTL and testbench
===================================

Name: acc_step_counter

Overview:
- Parametrised successor to the team's fixed 4-bit adder/counter: a registered accumulating counter that adds or subtracts a per-cycle step.
- Programmable modulus, wrap or saturate mode, synchronous load/clear, and overflow/underflow reporting.
- Used as the event/spike tally and timebase primitive in neuromorphic datapaths, e.g. accumulating weighted spike counts per timestep.

Parameters:
- WIDTH, 8, count register width in bits.
- STEP_W, 4, step input width; legal range 1..WIDTH.
- MAX_VAL, 2**WIDTH-1, highest count value. Legal range 2**STEP_W-1 .. 2**WIDTH-1. The count range is 0..MAX_VAL.
- SATURATE, 0, 0 = modulo (MAX_VAL+1) wrap; 1 = clamp at 0 / MAX_VAL.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- clear  input  1  synchronous clear of count and sticky flag.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  load value; values above MAX_VAL are clamped to MAX_VAL.
- en  input  1  count enable.
- up  input  1  1 = add step, 0 = subtract step.
- step  input  STEP_W  unsigned increment magnitude.
- count  output  WIDTH  registered count.
- ovf  output  1  one-cycle pulse: an up-step crossed MAX_VAL.
- unf  output  1  one-cycle pulse: a down-step crossed 0.
- err_sticky  output  1  set on any ovf/unf; held until clear or reset.

Behaviour:
- Reset: one clock, synchronous, active-low (rst_n low at a clk rising edge). Drives count=0, ovf=0, unf=0, err_sticky=0. Reset overrides every other input. Asserting it mid-accumulation discards the operation with no flag.
- Priority per edge: rst_n low > clear > load > en. Lower-priority inputs in the same cycle are ignored.
- clear: count<=0, err_sticky<=0, ovf/unf<=0.
- load: count<=min(load_val, MAX_VAL), ovf/unf<=0, err_sticky unchanged.
- en=0, or en=1 with step=0: count holds, ovf/unf<=0.
- Arithmetic is computed at WIDTH+1 bits so there is no intermediate truncation.
- Up, sum=count+step:
  - sum<=MAX_VAL: count<=sum.
  - sum>MAX_VAL, wrap mode: count<=sum-(MAX_VAL+1), ovf<=1.
  - sum>MAX_VAL, saturate mode: count<=MAX_VAL, ovf<=1.
- Down:
  - step<=count: count<=count-step.
  - step>count, wrap mode: count<=count+(MAX_VAL+1)-step, unf<=1.
  - step>count, saturate mode: count<=0, unf<=1.
- Exact landing is not overflow or underflow: count+step==MAX_VAL, or count-step==0.
- In saturate mode, stepping while already at the limit re-asserts ovf/unf every such cycle.
- Latency: count, ovf and unf all update on the same edge that samples en. They are visible in the following cycle. ovf/unf are high for exactly one cycle per event.
- err_sticky<=1 on the same edge as any ovf/unf. When clear and an overflow-causing en coincide, clear wins and err_sticky=0.
- count never exceeds MAX_VAL under any input sequence.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: ACC_STEP_COUNTER_MATCH_EN.
- Defined: adds input match_val [WIDTH] and output match [1].
  - match pulses for one cycle on the edge at which count is updated (by en or load) to a value equal to match_val.
  - match is 0 after reset and clear.
  - A hold with count already equal to match_val does not re-pulse.
- Undefined: neither port exists and no comparator logic is generated.

Test Plan:
- Reset: drive en=1, up=1, step=3 with rst_n=0 for 2 cycles. Required: count=0, ovf=unf=err_sticky=0. Release rst_n: count reads 3, then 6.
- Wrap up, with MAX_VAL=9, SATURATE=0: load 7, then en, up, step=5. Required: count=2, ovf pulses 1 cycle, err_sticky=1. A second step of 2 gives count=4 with ovf=0.
- Saturate down, with MAX_VAL=200, SATURATE=1: load 3, then down step=5 for 2 cycles. Required: count=0 both cycles, unf high both cycles. clear then drops err_sticky to 0.
- Boundaries, with defaults: load 250, up step=5 gives count=255 with ovf=0. A further up step=1 gives count=0 with ovf=1. load_val=300 with WIDTH=9, MAX_VAL=299 gives count=299.
- Priority: clear=1, load=1 (val=9), en=1 all in one cycle gives count=0. load=1 with en=1 gives count=load_val with no step applied.
- With ACC_STEP_COUNTER_MATCH_EN defined, match_val=6, step=2 up from 0: match pulses once, on the edge producing count=6. Holding en=0 afterwards leaves match=0.

Source files
------------

// File: rtl/acc_step_counter.sv
// acc_step_counter: registered up/down accumulating counter with programmable modulus,
// wrap or saturate mode, load/clear, and one-cycle ovf/unf pulses with a sticky error flag.
// Optional match comparator is enabled by defining ACC_STEP_COUNTER_MATCH_EN.
module acc_step_counter #(
    parameter int WIDTH    = 8,
    parameter int STEP_W   = 4,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter bit SATURATE = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              en,
    input  logic              up,
    input  logic [STEP_W-1:0] step,
`ifdef ACC_STEP_COUNTER_MATCH_EN
    input  logic [WIDTH-1:0]  match_val,
    output logic              match,
`endif
    output logic [WIDTH-1:0]  count,
    output logic              ovf,
    output logic              unf,
    output logic              err_sticky
);
    localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MAX_VAL + 1);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d, unf_q, unf_d, err_q, err_d;
    logic [WIDTH:0]   cur_x, step_x, sum_x, up_x, dn_x;
    logic             over, under, act;

    // Next-state arithmetic at WIDTH+1 bits, then priority clear > load > en.
    always_comb begin
        cur_x   = {1'b0, count_q};
        step_x  = (WIDTH+1)'(step);
        sum_x   = cur_x + step_x;
        over    = sum_x > MAX_X;
        under   = step_x > cur_x;
        up_x    = over ? (SATURATE ? MAX_X : sum_x - MOD_X) : sum_x;
        dn_x    = under ? (SATURATE ? '0 : cur_x + MOD_X - step_x) : cur_x - step_x;
        act     = en && (step != '0);
        count_d = clear ? '0
                : load  ? ((load_val > MAX_W) ? MAX_W : load_val)
                : act   ? WIDTH'(up ? up_x : dn_x)
                :         count_q;
        ovf_d   = !clear && !load && act && up && over;
        unf_d   = !clear && !load && act && !up && under;
        err_d   = !clear && (err_q || ovf_d || unf_d);
    end

`ifdef ACC_STEP_COUNTER_MATCH_EN
    logic match_q, match_d;

    // Pulse only when count is actually rewritten to the match value, not on holds.
    always_comb begin
        match_d = !clear && (load || act) && (count_d == match_val);
    end

    // Match flag register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) match_q <= 1'b0;
        else        match_q <= match_d;
    end

    assign match = match_q;
`endif

    // State registers; reset discards any in-flight operation without flagging.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            err_q   <= err_d;
        end
    end

    assign count      = count_q;
    assign ovf        = ovf_q;
    assign unf        = unf_q;
    assign err_sticky = err_q;
endmodule

// File: tb/tb_acc_step_counter.sv
// tb_acc_step_counter: four parameterisations driven in lockstep and checked against a behavioural model.
module tb_acc_step_counter;
    logic       clk = 1'b0;
    logic       rst_n, clear, load, en, up;
    logic [8:0] lv9, mv9;
    logic [3:0] step;
    logic [7:0] c0, c1, c2;
    logic [8:0] c3;
    logic [3:0] ovf_o, unf_o, err_o;
`ifdef ACC_STEP_COUNTER_MATCH_EN
    logic [3:0] match_o;
`endif

    int w[4]   = '{8, 8, 8, 9};
    int sw[4]  = '{4, 3, 4, 4};
    int mx[4]  = '{255, 9, 200, 299};
    int sat[4] = '{0, 0, 1, 0};
    int m_cnt[4];
    bit m_ovf[4], m_unf[4], m_err[4], m_match[4];
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    acc_step_counter #(.WIDTH(8), .STEP_W(4), .MAX_VAL(255), .SATURATE(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(lv9[7:0]),
        .en(en), .up(up), .step(step),
`ifdef ACC_STEP_COUNTER_MATCH_EN
        .match_val(mv9[7:0]), .match(match_o[0]),
`endif
        .count(c0), .ovf(ovf_o[0]), .unf(unf_o[0]), .err_sticky(err_o[0]));

    acc_step_counter #(.WIDTH(8), .STEP_W(3), .MAX_VAL(9), .SATURATE(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(lv9[7:0]),
        .en(en), .up(up), .step(step[2:0]),
`ifdef ACC_STEP_COUNTER_MATCH_EN
        .match_val(mv9[7:0]), .match(match_o[1]),
`endif
        .count(c1), .ovf(ovf_o[1]), .unf(unf_o[1]), .err_sticky(err_o[1]));

    acc_step_counter #(.WIDTH(8), .STEP_W(4), .MAX_VAL(200), .SATURATE(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(lv9[7:0]),
        .en(en), .up(up), .step(step),
`ifdef ACC_STEP_COUNTER_MATCH_EN
        .match_val(mv9[7:0]), .match(match_o[2]),
`endif
        .count(c2), .ovf(ovf_o[2]), .unf(unf_o[2]), .err_sticky(err_o[2]));

    acc_step_counter #(.WIDTH(9), .STEP_W(4), .MAX_VAL(299), .SATURATE(1'b0)) u3 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(lv9),
        .en(en), .up(up), .step(step),
`ifdef ACC_STEP_COUNTER_MATCH_EN
        .match_val(mv9), .match(match_o[3]),
`endif
        .count(c3), .ovf(ovf_o[3]), .unf(unf_o[3]), .err_sticky(err_o[3]));

    function automatic logic [31:0] cnt_of(int k);
        return k == 0 ? 32'(c0) : k == 1 ? 32'(c1) : k == 2 ? 32'(c2) : 32'(c3);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference model: applies the edge's rules to plain integers.
    task automatic model_step();
        for (int k = 0; k < 4; k++) begin
            int lv, st, s, mvk;
            bit act;
            lv  = int'(lv9) % (1 << w[k]);
            mvk = int'(mv9) % (1 << w[k]);
            st  = int'(step) % (1 << sw[k]);
            act = en && st != 0;
            if (!rst_n || clear) begin
                m_cnt[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; m_err[k] = 0; m_match[k] = 0;
            end else begin
                m_ovf[k] = 0;
                m_unf[k] = 0;
                if (load) m_cnt[k] = lv > mx[k] ? mx[k] : lv;
                else if (act && up) begin
                    s = m_cnt[k] + st;
                    if (s > mx[k]) begin
                        m_ovf[k] = 1;
                        s = sat[k] != 0 ? mx[k] : s - (mx[k] + 1);
                    end
                    m_cnt[k] = s;
                end else if (act) begin
                    s = m_cnt[k] - st;
                    if (s < 0) begin
                        m_unf[k] = 1;
                        s = sat[k] != 0 ? 0 : s + mx[k] + 1;
                    end
                    m_cnt[k] = s;
                end
                m_err[k]   = m_err[k] | m_ovf[k] | m_unf[k];
                m_match[k] = (load || act) && m_cnt[k] == mvk;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("count%0d", k), cnt_of(k), 32'(m_cnt[k]));
            chk($sformatf("ovf%0d", k), 32'(ovf_o[k]), 32'(m_ovf[k]));
            chk($sformatf("unf%0d", k), 32'(unf_o[k]), 32'(m_unf[k]));
            chk($sformatf("err%0d", k), 32'(err_o[k]), 32'(m_err[k]));
`ifdef ACC_STEP_COUNTER_MATCH_EN
            chk($sformatf("match%0d", k), 32'(match_o[k]), 32'(m_match[k]));
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
        step = 4'd3; lv9 = 9'd0; mv9 = 9'd0;
        tick(); tick();
        chk("rst_count", 32'(c0), 32'd0);
        chk("rst_err", 32'(err_o[0]), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_3", 32'(c0), 32'd3);
        tick();
        chk("post_rst_6", 32'(c0), 32'd6);

        load = 1'b1; lv9 = 9'd7; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1; step = 4'd5;
        tick();
        chk("wrap_count", 32'(c1), 32'd2);
        chk("wrap_ovf", 32'(ovf_o[1]), 32'd1);
        chk("wrap_err", 32'(err_o[1]), 32'd1);
        step = 4'd2;
        tick();
        chk("wrap_next", 32'(c1), 32'd4);
        chk("wrap_ovf_drop", 32'(ovf_o[1]), 32'd0);

        load = 1'b1; lv9 = 9'd3;
        tick();
        load = 1'b0; up = 1'b0; step = 4'd5;
        tick();
        chk("sat_dn1", 32'(c2), 32'd0);
        chk("sat_unf1", 32'(unf_o[2]), 32'd1);
        tick();
        chk("sat_dn2", 32'(c2), 32'd0);
        chk("sat_unf2", 32'(unf_o[2]), 32'd1);
        clear = 1'b1;
        tick();
        chk("sat_clear_err", 32'(err_o[2]), 32'd0);
        clear = 1'b0;

        load = 1'b1; lv9 = 9'd250;
        tick();
        load = 1'b0; up = 1'b1; step = 4'd5;
        tick();
        chk("exact_max", 32'(c0), 32'd255);
        chk("exact_no_ovf", 32'(ovf_o[0]), 32'd0);
        step = 4'd1;
        tick();
        chk("roll_zero", 32'(c0), 32'd0);
        chk("roll_ovf", 32'(ovf_o[0]), 32'd1);
        load = 1'b1; lv9 = 9'd300;
        tick();
        chk("load_clamp", 32'(c3), 32'd299);

        clear = 1'b1; load = 1'b1; lv9 = 9'd9; en = 1'b1; step = 4'd3;
        tick();
        chk("prio_clear", 32'(c0), 32'd0);
        clear = 1'b0;
        tick();
        chk("prio_load", 32'(c0), 32'd9);
        load = 1'b0;

`ifdef ACC_STEP_COUNTER_MATCH_EN
        clear = 1'b1; mv9 = 9'd6;
        tick();
        clear = 1'b0; en = 1'b1; up = 1'b1; step = 4'd2;
        tick();
        chk("match_at2", 32'(match_o[0]), 32'd0);
        tick();
        chk("match_at4", 32'(match_o[0]), 32'd0);
        tick();
        chk("match_at6", 32'(match_o[0]), 32'd1);
        en = 1'b0;
        tick();
        chk("match_hold", 32'(match_o[0]), 32'd0);
`endif

        for (int i = 0; i < 600; i++) begin
            rst_n = $urandom_range(0, 49) != 0;
            clear = $urandom_range(0, 24) == 0;
            load  = $urandom_range(0, 9) == 0;
            en    = $urandom_range(0, 3) != 0;
            up    = 1'($urandom_range(0, 1));
            step  = 4'($urandom_range(0, 15));
            lv9   = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 7) == 0) mv9 = 9'($urandom_range(0, 20));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
